// File: rtl/seg_scan_controller.sv
// seg_scan_controller: drives an active-low seven-segment bus shared by DIGITS
// positions. Each digit gets a BLANK gap and then a SHOW slot. Digit updates
// are double-buffered so that they only take effect at frame wraps.
module seg_scan_controller #(
  parameter int DIGITS       = 4,
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  upd_valid,
  input  logic [4*DIGITS-1:0]   upd_val,
  input  logic [DIGITS-1:0]     upd_en,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic [2:0]            cur_digit,
  output logic                  frame_done
);

  localparam int CNT_MAX = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {BLANK, SHOW} phase_t;

  phase_t                phase_q, phase_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]     shadow_en_q, shadow_en_d;
  logic [4*DIGITS-1:0]   pend_val_q, pend_val_d;
  logic [DIGITS-1:0]     pend_en_q, pend_en_d;
  logic                  pend_q, pend_d;
  logic                  started_q, started_d;
  logic [6:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [2:0]            cur_digit_q, cur_digit_d;
  logic                  frame_done_q, frame_done_d;
  logic                  wrap;
  logic [3:0]            nib;

  // Hex nibble to active-low gfedcba pattern
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Next-state: phase/counter sequencing, update buffering, registered outputs
  always_comb begin
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shadow_val_d = shadow_val_q;
    shadow_en_d  = shadow_en_q;
    pend_val_d   = pend_val_q;
    pend_en_d    = pend_en_q;
    pend_d       = pend_q;
    started_d    = 1'b1;
    wrap         = 1'b0;

    // The first edge after reset release is the entry edge of digit 0's
    // BLANK, so the counter holds there; this keeps SHOW at edge BLANK_CYCLES
    // and the first wrap at edge DIGITS*(BLANK_CYCLES+TICK_DIV).
    if (started_q) begin
      case (phase_q)
        BLANK: begin
          if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
            phase_d = SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          if (cnt_q == CW'(TICK_DIV - 1)) begin
            phase_d = BLANK;
            cnt_d   = '0;
            if (idx_q == IW'(DIGITS - 1)) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end

    // A strobe on the wrap edge bypasses the pending buffer and supersedes it
    if (wrap) begin
      if (upd_valid) begin
        shadow_val_d = upd_val;
        shadow_en_d  = upd_en;
      end else if (pend_q) begin
        shadow_val_d = pend_val_q;
        shadow_en_d  = pend_en_q;
      end
      pend_d = 1'b0;
    end else if (upd_valid) begin
      pend_val_d = upd_val;
      pend_en_d  = upd_en;
      pend_d     = 1'b1;
    end

    nib          = shadow_val_d[4*int'(idx_d) +: 4];
    seg_d        = 7'h7F;
    an_d         = '1;
    if (phase_d == SHOW && shadow_en_d[idx_d]) begin
      seg_d        = decode(nib);
      an_d[idx_d]  = 1'b0;
    end
    cur_digit_d  = 3'(idx_d);
    frame_done_d = wrap;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q      <= BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_en_q  <= '0;
      pend_val_q   <= '0;
      pend_en_q    <= '0;
      pend_q       <= 1'b0;
      started_q    <= 1'b0;
      seg_q        <= 7'h7F;
      an_q         <= '1;
      cur_digit_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_en_q  <= shadow_en_d;
      pend_val_q   <= pend_val_d;
      pend_en_q    <= pend_en_d;
      pend_q       <= pend_d;
      started_q    <= started_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      cur_digit_q  <= cur_digit_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign cur_digit  = cur_digit_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller: scoreboard bench for seg_scan_controller with
// DIGITS=4, TICK_DIV=4, BLANK_CYCLES=2 (24-cycle frame). Cycle c means the
// outputs following edge c, edge 0 being the first edge with reset high.
module tb_seg_scan_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_val = '0;
  logic [3:0]  upd_en = '0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [2:0]  cur_digit;
  logic        frame_done;

  seg_scan_controller #(.DIGITS(4), .TICK_DIV(4), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .upd_valid(upd_valid), .upd_val(upd_val),
    .upd_en(upd_en), .seg(seg), .an(an), .cur_digit(cur_digit),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [6:0] seg;
    logic [3:0] an;
    logic [2:0] cur;
    logic       fd;
  } exp_t;

  exp_t  q[$];
  int    cyc = -1;
  int    errors = 0;
  int    checks = 0;
  string scen = "init";

  localparam logic [6:0] DARK = 7'h7F;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S6 = 7'b0000010;
  localparam logic [6:0] S8 = 7'b0000000, SF = 7'b0001110;

  always @(posedge clk) begin
    if (!reset) cyc <= -1;
    else        cyc <= cyc + 1;
  end

  // Monitor: pops the expectation for the current cycle and compares
  always @(negedge clk) begin
    if (q.size() > 0 && cyc >= 0 && q[0].cyc < cyc) begin
      errors++;
      checks++;
      $display("FAIL %s missed cyc=%0d (now %0d)", scen, q[0].cyc, cyc);
      void'(q.pop_front());
    end
    while (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (seg !== e.seg || an !== e.an || cur_digit !== e.cur || frame_done !== e.fd) begin
        errors++;
        $display("FAIL %s cyc=%0d: got seg=%b an=%h cur=%0d fd=%b, expected seg=%b an=%h cur=%0d fd=%b",
                 scen, cyc, seg, an, cur_digit, frame_done, e.seg, e.an, e.cur, e.fd);
      end
    end
  end

  task automatic push_one(input int c, input logic [6:0] s, input logic [3:0] a,
                          input logic [2:0] cur, input logic fd);
    exp_t e;
    e.cyc = c; e.seg = s; e.an = a; e.cur = cur; e.fd = fd;
    q.push_back(e);
  endtask

  // One digit slot: 2 BLANK cycles then 4 SHOW cycles showing s on anodes a
  task automatic push_slot(input int c0, input int d, input logic [6:0] s, input logic [3:0] a);
    int b;
    b = c0 + d * 6;
    push_one(b,     DARK, 4'hF, 3'(d), (d == 0 && c0 > 0));
    push_one(b + 1, DARK, 4'hF, 3'(d), 1'b0);
    for (int k = 2; k < 6; k++) push_one(b + k, s, a, 3'(d), 1'b0);
  endtask

  task automatic push_dark_frame(input int c0);
    for (int d = 0; d < 4; d++) push_slot(c0, d, DARK, 4'hF);
  endtask

  task automatic wait_cyc(input int c);
    int n;
    n = 0;
    while (cyc != c) begin
      @(posedge clk); #1;
      n++;
      if (n > 500) begin
        errors++;
        $display("FAIL %s wait_cyc(%0d) timed out", scen, c);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
      end
    end
  endtask

  // Assert reset for two edges and queue the reset-state check
  task automatic hold_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    upd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    push_one(-1, DARK, 4'hF, 3'd0, 1'b0);
  endtask

  task automatic release_reset();
    @(negedge clk); #1;
    reset = 1'b1;
  endtask

  // Strobe so that edge e samples upd_valid=1
  task automatic upd_at(input int e, input logic [15:0] v, input logic [3:0] en);
    wait_cyc(e - 1);
    upd_valid = 1'b1; upd_val = v; upd_en = en;
    @(posedge clk); #1;
    upd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0) begin
      @(posedge clk);
      n++;
      if (n > 200) begin
        errors++;
        $display("FAIL %s drain timed out, %0d left", scen, q.size());
        q.delete();
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: no update, dark display, frame_done every 24 cycles
    scen = "idle";
    hold_reset();
    push_dark_frame(0); push_dark_frame(24); push_dark_frame(48);
    push_one(72, DARK, 4'hF, 3'd0, 1'b1);
    release_reset();
    drain();

    // 2: update at edge 3 appears only in the next frame
    scen = "single_upd";
    hold_reset();
    push_dark_frame(0);
    push_slot(24, 0, S0, 4'hE); push_slot(24, 1, S1, 4'hD);
    push_slot(24, 2, S2, 4'hB); push_slot(24, 3, S3, 4'h7);
    release_reset();
    upd_at(3, 16'h3210, 4'hF);
    drain();

    // 3: last update in a frame wins
    scen = "last_wins";
    hold_reset();
    push_dark_frame(0);
    push_slot(24, 0, SF, 4'hE); push_slot(24, 1, SF, 4'hD);
    push_slot(24, 2, SF, 4'hB); push_slot(24, 3, SF, 4'h7);
    release_reset();
    upd_at(5, 16'h1111, 4'hF);
    upd_at(10, 16'hFFFF, 4'hF);
    drain();

    // 4: wrap-edge update bypasses and drops older pending data
    scen = "wrap_bypass";
    hold_reset();
    push_dark_frame(0);
    for (int f = 24; f <= 48; f += 24) begin
      push_slot(f, 0, S8, 4'hE); push_slot(f, 1, S8, 4'hD);
      push_slot(f, 2, S8, 4'hB); push_slot(f, 3, S8, 4'h7);
    end
    release_reset();
    upd_at(5, 16'h4444, 4'hF);
    upd_at(24, 16'h8888, 4'hF);
    drain();

    // 5: disabled digits stay dark but keep their slots
    scen = "enable_mask";
    hold_reset();
    push_dark_frame(0);
    push_slot(24, 0, S4, 4'hE); push_slot(24, 1, DARK, 4'hF);
    push_slot(24, 2, S6, 4'hB); push_slot(24, 3, DARK, 4'hF);
    release_reset();
    upd_at(3, 16'h7654, 4'b0101);
    drain();

    // 6: reset during digit 2 SHOW clears everything, display stays dark
    scen = "mid_reset";
    hold_reset();
    push_dark_frame(0);
    push_slot(24, 0, S0, 4'hE); push_slot(24, 1, S1, 4'hD);
    push_one(36, DARK, 4'hF, 3'd2, 1'b0);
    push_one(37, DARK, 4'hF, 3'd2, 1'b0);
    push_one(38, S2, 4'hB, 3'd2, 1'b0);
    release_reset();
    upd_at(3, 16'h3210, 4'hF);
    wait_cyc(38);
    reset = 1'b0;
    push_one(-1, DARK, 4'hF, 3'd0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    push_dark_frame(0); push_dark_frame(24);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
